uart_rx: RTL and testbench

Receive half of the UART link: recovers 8-bit frames from the serial line driven by `uart_TX` (start bit, 8 data bits LSB first, optional parity, one stop bit). It oversamples the line by a runtime-selectable prescale and checks parity and stop bit. Each good byte is presented as a one-cycle `data_valid` pulse with `p_data` for the register file / system controller. It sits directly downstream of the transmitter's `S_data` output, in the same clock domain family.

---
 rtl/uart_rx_if.sv | 23 ++
 rtl/uart_rx.sv | 143 ++++++++++++++
 tb/tb_uart_rx.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Receiver-side bundle for uart_rx: serial line, frame configuration and decoded outputs.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx_in;
    logic [5:0]            prescale;
    logic                  par_en;
    logic                  par_type;
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_err;
    logic                  stop_err;

    modport master (
        output rx_in, prescale, par_en, par_type,
        input  p_data, data_valid, par_err, stop_err
    );

    modport slave (
        input  rx_in, prescale, par_en, par_type,
        output p_data, data_valid, par_err, stop_err
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: oversampled 8N1/8P1 frame recovery with parity and stop checks.
// Define UART_RX_MAJORITY_EN for a 2-of-3 vote around the mid-bit sample point.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);

    state_t                state;
    logic                  sync1;
    logic                  rx_s;
    logic [5:0]            prescale_eff;
    logic [5:0]            p_lat;
    logic [5:0]            half;
    logic [5:0]            last;
    logic [5:0]            edge_cnt;
    logic [2:0]            bit_cnt;
    logic                  par_en_l;
    logic                  par_type_l;
    logic                  par_bad;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  bit_end;
    logic                  bit_val;
    logic                  arm;

    always_comb begin
        prescale_eff = 6'd8;
        if (bus.prescale == 6'd16 || bus.prescale == 6'd32)
            prescale_eff = bus.prescale;
    end

    assign half    = {1'b0, p_lat[5:1]};
    assign last    = p_lat - 6'd1;
    assign bit_end = (edge_cnt == last);
    // A start may be taken from IDLE or straight out of a finishing stop bit (back-to-back frames).
    assign arm     = !rx_s && (state == IDLE || (state == STOP && bit_end));

`ifdef UART_RX_MAJORITY_EN
    logic [2:0] votes;

    always_ff @(posedge clk) begin
        if (rst) begin
            votes <= '1;
        end else if (state != IDLE) begin
            if (edge_cnt == half - 6'd1) votes[0] <= rx_s;
            if (edge_cnt == half)        votes[1] <= rx_s;
            if (edge_cnt == half + 6'd1) votes[2] <= rx_s;
        end
    end

    assign bit_val = (votes[0] & votes[1]) | (votes[0] & votes[2]) | (votes[1] & votes[2]);
`else
    logic smp;

    always_ff @(posedge clk) begin
        if (rst) begin
            smp <= 1'b1;
        end else if (state != IDLE && edge_cnt == half) begin
            smp <= rx_s;
        end
    end

    assign bit_val = smp;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            sync1          <= 1'b1;
            rx_s           <= 1'b1;
            p_lat          <= 6'd8;
            edge_cnt       <= '0;
            bit_cnt        <= '0;
            par_en_l       <= 1'b0;
            par_type_l     <= 1'b0;
            par_bad        <= 1'b0;
            shreg          <= '0;
            bus.p_data     <= '0;
            bus.data_valid <= 1'b0;
            bus.par_err    <= 1'b0;
            bus.stop_err   <= 1'b0;
        end else begin
            sync1          <= bus.rx_in;
            rx_s           <= sync1;
            bus.data_valid <= 1'b0;
            bus.par_err    <= 1'b0;
            bus.stop_err   <= 1'b0;

            if (state != IDLE)
                edge_cnt <= bit_end ? '0 : edge_cnt + 6'd1;

            case (state)
                IDLE: ;
                START: begin
                    if (bit_end)
                        state <= bit_val ? IDLE : DATA;
                end
                DATA: begin
                    if (bit_end) begin
                        shreg   <= {bit_val, shreg[DATA_WIDTH-1:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == LAST_BIT)
                            state <= par_en_l ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        par_bad <= (bit_val != (^shreg ^ par_type_l));
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        if (bit_val && !par_bad) begin
                            bus.data_valid <= 1'b1;
                            bus.p_data     <= shreg;
                        end
                        bus.par_err  <= par_bad;
                        bus.stop_err <= !bit_val;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Overrides the STOP->IDLE move above when the next start bit is already on the line.
            if (arm) begin
                state      <= START;
                p_lat      <= prescale_eff;
                par_en_l   <= bus.par_en;
                par_type_l <= bus.par_type;
                edge_cnt   <= '0;
                bit_cnt    <= '0;
                par_bad    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: waveform-level frame model plus per-cycle output compare.
module tb_uart_rx;
    typedef struct packed {
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] data;
    } evt_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_if #(.DATA_WIDTH(8)) bus ();

    uart_rx #(.DATA_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    evt_t       evts [int];
    logic [7:0] exp_pdata   = 8'h00;
    int         last_dv_cyc = -1;
    int         last_pe_cyc = -1;
    int         last_se_cyc = -1;
    bit         abort       = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Outputs are checked every cycle, 1 time unit after the edge that registered them.
    initial begin
        evt_t e;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            e = '0;
            if (rst) begin
                evts.delete();
                exp_pdata = 8'h00;
            end else if (evts.exists(cyc)) begin
                e = evts[cyc];
                evts.delete(cyc);
                if (e.dv) exp_pdata = e.data;
            end
            check("data_valid", 32'(bus.data_valid), 32'(e.dv));
            check("par_err", 32'(bus.par_err), 32'(e.pe));
            check("stop_err", 32'(bus.stop_err), 32'(e.se));
            check("p_data", 32'(bus.p_data), 32'(exp_pdata));
            if (bus.data_valid === 1'b1) last_dv_cyc = cyc;
            if (bus.par_err === 1'b1)    last_pe_cyc = cyc;
            if (bus.stop_err === 1'b1)   last_se_cyc = cyc;
        end
    end

    task automatic idle(input int n);
        bus.rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_low(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.rx_in = 1'b0;
        end
        @(negedge clk);
        bus.rx_in = 1'b1;
    endtask

    // Builds the per-clock line waveform, predicts the receiver's verdict from it, then drives it.
    task automatic send_frame(input logic [7:0] d, input bit tx_odd, input bit stop_bad,
                              input int glitch_k, output int start_edge);
        logic       line [$];
        logic [10:0] fb;
        logic       sv [0:10];
        logic [7:0] d_rx;
        int         pe_;
        int         nb;
        bit         pen;
        bit         pt;
        bit         perr;
        logic       stopv;
        evt_t       e;
        pen = bus.par_en;
        pt  = bus.par_type;
        pe_ = (bus.prescale == 6'd16 || bus.prescale == 6'd32) ? int'(bus.prescale) : 8;
        nb  = 10 + int'(pen);
        fb  = '0;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[1 + i] = d[i];
        if (pen) fb[9] = (^d) ^ tx_odd;
        fb[nb - 1] = !stop_bad;
        for (int k = 0; k < nb; k++) begin
            for (int o = 1; o <= pe_; o++) begin
                logic v;
                v = fb[k];
                if (k == glitch_k && o == pe_ / 2 + 2) v = ~v;
                line.push_back(v);
            end
        end
        for (int k = 0; k < nb; k++) begin
            int b;
            b = k * pe_ + pe_ / 2;
`ifdef UART_RX_MAJORITY_EN
            sv[k] = (line[b] & line[b+1]) | (line[b] & line[b+2]) | (line[b+1] & line[b+2]);
`else
            sv[k] = line[b+1];
`endif
        end
        @(negedge clk);
        start_edge = cyc + 1;
        if (sv[0] == 1'b0) begin
            for (int i = 0; i < 8; i++) d_rx[i] = sv[i + 1];
            perr  = pen && (sv[9] != ((^d_rx) ^ pt));
            stopv = sv[nb - 1];
            e.dv   = stopv && !perr;
            e.pe   = perr;
            e.se   = !stopv;
            e.data = d_rx;
            evts[start_edge + nb * pe_ + 2] = e;
        end
        bus.rx_in = line[0];
        for (int i = 1; i < line.size(); i++) begin
            @(negedge clk);
            if (abort) begin
                bus.rx_in = 1'b1;
                break;
            end
            bus.rx_in = line[i];
        end
    endtask

    initial begin
        int s1;
        int s2;
        int prev_dv;
        bus.rx_in    = 1'b1;
        bus.prescale = 6'd8;
        bus.par_en   = 1'b0;
        bus.par_type = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_p_data", 32'(bus.p_data), 32'h00);
        check("reset_data_valid", 32'(bus.data_valid), 32'h0);

        idle(200);

        // Good frame, even parity, P=8
        bus.par_en = 1'b1;
        bus.par_type = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b0, -1, s1);
        idle(10);
        check("a5_latency", 32'(last_dv_cyc - s1 + 1), 32'd91);
        check("a5_p_data", 32'(bus.p_data), 32'hA5);

        // Parity mismatch: transmitter even, receiver odd
        prev_dv = last_dv_cyc;
        bus.par_type = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0, -1, s1);
        idle(10);
        check("3c_par_err_latency", 32'(last_pe_cyc - s1 + 1), 32'd91);
        check("3c_no_data_valid", 32'(last_dv_cyc), 32'(prev_dv));
        check("3c_p_data_held", 32'(bus.p_data), 32'hA5);

        // Stop error then back-to-back good frame, P=16
        bus.prescale = 6'd16;
        bus.par_en = 1'b0;
        bus.par_type = 1'b0;
        idle(5);
        send_frame(8'h99, 1'b0, 1'b1, -1, s1);
        send_frame(8'h0F, 1'b0, 1'b0, -1, s2);
        idle(10);
        check("stop_err_latency", 32'(last_se_cyc - s1 + 1), 32'd163);
        check("b2b_start_gap", 32'(s2 - s1), 32'd160);
        check("0f_latency", 32'(last_dv_cyc - s2 + 1), 32'd163);
        check("0f_p_data", 32'(bus.p_data), 32'h0F);

        // False start, then a glitch on data bit 3 of 0x55
        idle(20);
        prev_dv = last_dv_cyc;
        pulse_low(3);
        idle(40);
        check("false_start_no_dv", 32'(last_dv_cyc), 32'(prev_dv));
        send_frame(8'h55, 1'b0, 1'b0, 4, s1);
        idle(10);
        check("glitch_latency", 32'(last_dv_cyc - s1 + 1), 32'd163);
`ifdef UART_RX_MAJORITY_EN
        check("glitch_p_data", 32'(bus.p_data), 32'h55);
`else
        check("glitch_p_data", 32'(bus.p_data), 32'h5D);
`endif

        // Reset during data bit 4, then a frame with configuration changed mid-frame
        bus.prescale = 6'd8;
        idle(5);
        fork
            send_frame(8'h5A, 1'b0, 1'b0, -1, s1);
            begin
                repeat (43) @(negedge clk);
                rst = 1'b1;
                abort = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("midreset_p_data", 32'(bus.p_data), 32'h00);
                check("midreset_data_valid", 32'(bus.data_valid), 32'h0);
                check("midreset_par_err", 32'(bus.par_err), 32'h0);
                check("midreset_stop_err", 32'(bus.stop_err), 32'h0);
            end
        join
        abort = 1'b0;
        idle(20);
        fork
            send_frame(8'h81, 1'b0, 1'b0, -1, s1);
            begin
                repeat (30) @(negedge clk);
                bus.prescale = 6'd32;
                bus.par_en = 1'b1;
                bus.par_type = 1'b1;
            end
        join
        idle(20);
        check("81_latency", 32'(last_dv_cyc - s1 + 1), 32'd83);
        check("81_p_data", 32'(bus.p_data), 32'h81);

        idle(50);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
